wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//   Single-port register-file write scheduler placed after the write-back stage.
//   Shares the one rd write port between the in-order pipeline write-back and a
//   long-latency unit (mul/div) whose results arrive out of band.
//   Long-latency results wait in a small in-order buffer. The pipeline is stalled
//   only when the buffer must drain, i.e. when it is full or its head has starved.
// PARAMETERS
//   XLEN          64  data width of rd write data
//   REG_IDX_W     5   register index width
//   LL_DEPTH      2   long-latency buffer entries (power of two, >=2)
//   STARVE_LIMIT  8   cycles the buffer head may wait before a forced drain
// PORTS
//   i_clk        in   1          clock, all state on rising edge
//   i_rst_n      in   1          asynchronous active-low reset
//   i_pipe_we    in   1          pipeline write-back request this cycle
//   i_pipe_rd    in   REG_IDX_W  pipeline destination index
//   i_pipe_data  in   XLEN       pipeline write data
//   i_ll_valid   in   1          long-latency result valid
//   o_ll_ready   out  1          buffer can accept (valid&&ready = push)
//   i_ll_rd      in   REG_IDX_W  long-latency destination index
//   i_ll_data    in   XLEN       long-latency result
//   o_rd_we      out  1          register-file write enable (registered)
//   o_rd_index   out  REG_IDX_W  register-file write index (registered)
//   o_rd_data    out  XLEN       register-file write data (registered)
//   o_stall      out  1          freeze pipeline; i_pipe_* ignored while high
//   o_ll_pending out  1          buffer non-empty
// BEHAVIOUR
//   Reset (async, any time, mid-drain included):
//     o_rd_we=0, o_rd_index=0, o_rd_data=0, o_stall=0, state=PIPE,
//     buffer empty (contents discarded), age=0. o_ll_ready=1 from the first
//     cycle after deassertion.
//   Latency: a winner sampled at edge N appears on o_rd_* after edge N; one
//     write per cycle at most.
//   o_ll_ready = (count < LL_DEPTH), from registered count only. Push and pop in
//     the same cycle are allowed when not full. No push is possible when full.
//   FSM state PIPE (o_stall=0):
//     - i_pipe_we=1 and i_pipe_rd!=0: pipeline wins the port.
//     - i_pipe_rd==0 or i_pipe_we=0: port is free. Buffer head pops and is
//       written if non-empty, else o_rd_we=0.
//     - A pipeline write to x0 is never emitted.
//   age: counts cycles with buffer non-empty and no pop. Clears on pop or empty.
//   PIPE->DRAIN when, at end of cycle, count==LL_DEPTH or age==STARVE_LIMIT.
//   FSM state DRAIN (o_stall=1):
//     - head pops every cycle. i_pipe_* are ignored; the pipeline holds them.
//     - pushes are still accepted if not full.
//     - DRAIN->PIPE at the edge where the buffer becomes empty, i.e. pop with
//       count==1 and no push. The first PIPE cycle serves the pipeline.
//   Buffer entries with rd==0 are popped without a write (o_rd_we=0).
//   Order: buffer strictly FIFO. WAW between pipeline and buffer is excluded by
//     the issue scoreboard; this block does not reorder or detect it.
//   o_ll_pending = (count != 0), registered.
// STRUCTURE
//   Package wb_arb_pkg:
//     - typedef enum logic {PIPE, DRAIN} wb_arb_state_t
//     - typedef struct {rd, data} wb_req_t
//     - defaults XLEN, REG_IDX_W
//   Sub-module wb_ll_fifo: synchronous FIFO, depth LL_DEPTH, async active-low
//     reset, ports push/pop/full/empty/count/head. The arbiter FSM, age counter
//     and output registers live in wb_port_arbiter.
// TESTING
//   1 Reset mid-DRAIN with 2 buffered entries -> o_stall=0, o_rd_we=0,
//     o_ll_pending=0 immediately; o_ll_ready=1 next cycle.
//   2 Pipe only: we=1, rd=5, data=0xAB each cycle -> o_rd_we=1, idx=5,
//     data=0xAB one cycle later; o_stall never asserts.
//   3 Pipe rd=0 while buffer holds {rd=7,data=0x42} -> next cycle o_rd_we=1,
//     idx=7, data=0x42; no write to x0.
//   4 Pipe busy every cycle, push 2 LL results -> count=2, o_ll_ready=0,
//     o_stall=1 next cycle. Both drain in order over 2 cycles, then o_stall=0.
//     Held pipe request is written on the following cycle.
//   5 Pipe busy, 1 LL entry waiting -> o_stall asserts after exactly 8 wait
//     cycles, entry is written, then PIPE resumes.
//   6 In DRAIN with count=1, push and pop same cycle -> stays DRAIN one more
//     cycle; exits only when empty.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the write-back port arbiter and its
// long-latency result buffer.
package wb_arb_pkg;

  localparam int DEFAULT_XLEN      = 64;
  localparam int DEFAULT_REG_IDX_W = 5;

  typedef enum logic {
    PIPE  = 1'b0,
    DRAIN = 1'b1
  } wb_arb_state_t;

  typedef struct packed {
    logic [DEFAULT_REG_IDX_W-1:0] rd;
    logic [DEFAULT_XLEN-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// In-order buffer for long-latency results. Power-of-two depth; head holds the
// oldest entry and is meaningful whenever empty is low.
module wb_ll_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Guard against overflow/underflow even if the caller misbehaves
  always_comb begin
    do_push_s = push && (count_r != CNT_W'(DEPTH));
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Entry storage; stale contents are unreachable once the pointers reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single rd write port between in-order write-back (priority) and
// buffered long-latency results, stalling the pipeline only to force a drain.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int REG_IDX_W    = DEFAULT_REG_IDX_W,
  parameter int LL_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pipe_we,
  input  logic [REG_IDX_W-1:0] i_pipe_rd,
  input  logic [XLEN-1:0]      i_pipe_data,
  input  logic                 i_ll_valid,
  output logic                 o_ll_ready,
  input  logic [REG_IDX_W-1:0] i_ll_rd,
  input  logic [XLEN-1:0]      i_ll_data,
  output logic                 o_rd_we,
  output logic [REG_IDX_W-1:0] o_rd_index,
  output logic [XLEN-1:0]      o_rd_data,
  output logic                 o_stall,
  output logic                 o_ll_pending
);

  localparam int CNT_W   = $clog2(LL_DEPTH + 1);
  localparam int AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam int ENTRY_W = REG_IDX_W + XLEN;

  wb_arb_state_t        state_r;
  wb_arb_state_t        state_nxt_s;
  logic [AGE_W-1:0]     age_r;
  logic [AGE_W-1:0]     age_nxt_s;
  logic [CNT_W-1:0]     count_s;
  logic [CNT_W-1:0]     count_nxt_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 serve_pipe_s;
  logic [ENTRY_W-1:0]   push_entry_s;
  logic [ENTRY_W-1:0]   head_s;
  logic [REG_IDX_W-1:0] head_rd_s;
  logic [XLEN-1:0]      head_data_s;
  logic                 wr_en_s;
  logic [REG_IDX_W-1:0] wr_index_s;
  logic [XLEN-1:0]      wr_data_s;
  logic                 rd_we_r;
  logic [REG_IDX_W-1:0] rd_index_r;
  logic [XLEN-1:0]      rd_data_r;

  assign push_entry_s = {i_ll_rd, i_ll_data};
  assign head_rd_s    = head_s[ENTRY_W-1 -: REG_IDX_W];
  assign head_data_s  = head_s[XLEN-1:0];
  assign push_s       = i_ll_valid && !full_s;

  wb_ll_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LL_DEPTH),
    .CNT_W (CNT_W)
  ) u_ll_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s),
    .head  (head_s)
  );

  // Port winner: live x0-free write-back in PIPE, otherwise the buffer head
  always_comb begin
    serve_pipe_s = (state_r == PIPE) && i_pipe_we && (i_pipe_rd != {REG_IDX_W{1'b0}});
    pop_s        = !serve_pipe_s && !empty_s;
    wr_en_s      = 1'b0;
    wr_index_s   = rd_index_r;
    wr_data_s    = rd_data_r;
    if (serve_pipe_s) begin
      wr_en_s    = 1'b1;
      wr_index_s = i_pipe_rd;
      wr_data_s  = i_pipe_data;
    end else if (pop_s && (head_rd_s != {REG_IDX_W{1'b0}})) begin
      wr_en_s    = 1'b1;
      wr_index_s = head_rd_s;
      wr_data_s  = head_data_s;
    end else begin
      wr_en_s    = 1'b0;
    end
  end

  // Head age and drain decisions, judged on end-of-cycle occupancy
  always_comb begin
    count_nxt_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    state_nxt_s = state_r;
    if (pop_s || empty_s) begin
      age_nxt_s = {AGE_W{1'b0}};
    end else if (age_r != AGE_W'(STARVE_LIMIT)) begin
      age_nxt_s = age_r + AGE_W'(1);
    end else begin
      age_nxt_s = age_r;
    end
    case (state_r)
      PIPE: begin
        if ((count_nxt_s == CNT_W'(LL_DEPTH)) || (age_nxt_s == AGE_W'(STARVE_LIMIT))) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = PIPE;
        end
      end
      DRAIN: begin
        if (count_nxt_s == {CNT_W{1'b0}}) begin
          state_nxt_s = PIPE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = PIPE;
    endcase
  end

  // FSM state and head age registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= PIPE;
      age_r   <= {AGE_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      age_r   <= age_nxt_s;
    end
  end

  // Registered write port; index/data hold when no write is issued
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_we_r    <= 1'b0;
      rd_index_r <= {REG_IDX_W{1'b0}};
      rd_data_r  <= {XLEN{1'b0}};
    end else begin
      rd_we_r    <= wr_en_s;
      rd_index_r <= wr_index_s;
      rd_data_r  <= wr_data_s;
    end
  end

  assign o_rd_we      = rd_we_r;
  assign o_rd_index   = rd_index_r;
  assign o_rd_data    = rd_data_r;
  assign o_stall      = (state_r == DRAIN);
  assign o_ll_pending = !empty_s;
  assign o_ll_ready   = !full_s;

endmodule
